multicycle_control_fsm: RTL and testbench

//  Main sequencer for the multicycle RISC datapath. Walks each instruction through

---
 rtl/multicycle_control_fsm_if.sv | 46 ++++
 rtl/multicycle_control_fsm.sv | 265 ++++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the datapath/memory.
//   master : sequencer side (receives opcode/zero/mem_ready, drives all controls)
//   slave  : datapath side (drives opcode/zero/mem_ready, receives all controls)
// Signals:
//   opcode[5:0]    IR[31:26], valid from DECODE onward
//   zero           ALU zero flag, same-cycle
//   mem_ready      memory read data valid / write accepted
//   mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
//   alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0], pc_en
//   state_dbg[3:0] current sequencer state
//   illegal_op     sticky undefined-opcode flag
//   bus_error      sticky memory-timeout flag
interface multicycle_control_fsm_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       pc_en;
  logic [3:0] state_dbg;
  logic       illegal_op;
  logic       bus_error;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_source, pc_en, state_dbg,
           illegal_op, bus_error
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_source, pc_en, state_dbg,
           illegal_op, bus_error
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multicycle RISC datapath. Steps each instruction through
// fetch/decode/execute/memory/writeback, drives datapath selects and enables,
// handshakes with the shared memory and traps on illegal opcodes or memory
// timeouts.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    control bundle (master side), see multicycle_control_fsm_if
// Controls are decoded from the state register (Moore). The exceptions are
// ir_write/pc_write in FETCH, qualified by mem_ready, and pc_en, which folds in
// the same-cycle zero flag. Because the decode comes straight from the state
// register, asserting rst_n drops every request in the same instant.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_fsm_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    ST_RST      = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WB   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_EXEC     = 4'd7,
    ST_ALU_WB   = 4'd8,
    ST_ADDI_WB  = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_ERROR    = 4'd12
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             illegal_q, bus_err_q;

  logic             timeout_hit;
  logic             wait_mem;
  logic             set_illegal;
  logic             set_bus_err;
  logic             pc_write;
  logic             pc_write_cond;

  logic             mem_read;
  logic             mem_write;
  logic             iord;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;

  // The wait that would push the count to MEM_TIMEOUT is the one that traps;
  // mem_ready in that same cycle still completes the access.
  assign timeout_hit = (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory wait counter: cleared on any state change, counts stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (state_d != state_q) begin
      wait_cnt_q <= '0;
    end else if (wait_mem) begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end

  // Sticky fault flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      illegal_q <= illegal_q | set_illegal;
      bus_err_q <= bus_err_q | set_bus_err;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d       = state_q;
    wait_mem      = 1'b0;
    set_illegal   = 1'b0;
    set_bus_err   = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;

    unique case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
      end

      // PC + 4 computed while the instruction is read.
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (timeout_hit) begin
          set_bus_err = 1'b1;
          state_d     = ST_ERROR;
        end else begin
          wait_mem = 1'b1;
        end
      end

      // Branch target (PC + imm<<2) into ALUOut speculatively.
      ST_DECODE: begin
        alu_src_b = 2'b11;
        unique case (bus.opcode)
          OP_RTYPE:             state_d = ST_EXEC;
          OP_LW, OP_SW, OP_ADDI: state_d = ST_MEM_ADDR;
          OP_BEQ:               state_d = ST_BRANCH;
          OP_J:                 state_d = ST_JUMP;
          default: begin
            set_illegal = 1'b1;
            state_d     = ST_ERROR;
          end
        endcase
      end

      // Shared by lw/sw/addi: regA + sign-extended immediate.
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        unique case (bus.opcode)
          OP_LW:   state_d = ST_MEM_RD;
          OP_SW:   state_d = ST_MEM_WR;
          OP_ADDI: state_d = ST_ADDI_WB;
          default: begin
            set_illegal = 1'b1;
            state_d     = ST_ERROR;
          end
        endcase
      end

      ST_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) begin
          state_d = ST_MEM_WB;
        end else if (timeout_hit) begin
          set_bus_err = 1'b1;
          state_d     = ST_ERROR;
        end else begin
          wait_mem = 1'b1;
        end
      end

      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.mem_ready) begin
          state_d = ST_FETCH;
        end else if (timeout_hit) begin
          set_bus_err = 1'b1;
          state_d     = ST_ERROR;
        end else begin
          wait_mem = 1'b1;
        end
      end

      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = ST_ALU_WB;
      end

      ST_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = ST_FETCH;
      end

      ST_ADDI_WB: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end

      // regA - regB sets zero; PC loads ALUOut only when equal.
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = ST_FETCH;
      end

      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = ST_FETCH;
      end

      ST_ERROR: begin
        state_d = ST_ERROR;
      end

      default: begin
        state_d = ST_ERROR;
      end
    endcase
  end

  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.iord       = iord;
  assign bus.ir_write   = ir_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_write  = reg_write;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.pc_source  = pc_source;
  assign bus.pc_en      = pc_write | (pc_write_cond & bus.zero);
  assign bus.state_dbg  = state_q;
  assign bus.illegal_op = illegal_q;
  assign bus.bus_error  = bus_err_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: instruction sequences, stalls,
// branch outcomes, illegal opcode trap, memory timeout and mid-access reset.
module tb_multicycle_control_fsm;

  localparam int unsigned MEM_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  multicycle_control_fsm_if bus();

  multicycle_control_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // {mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
  //  alu_src_a, alu_src_b, alu_op, pc_source, pc_en}
  logic [14:0] ctl;
  assign ctl = {bus.mem_read, bus.mem_write, bus.iord, bus.ir_write, bus.reg_dst,
                bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.pc_source, bus.pc_en};

  int n_checks = 0;
  int n_errors = 0;

  int          cyc, rw_n, pe_n, ir_n, rd_n, wr_n;
  logic [31:0] trace;
  logic [14:0] ctl_tr [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] cw(input logic mr, input logic mw, input logic io,
                                     input logic irw, input logic rd, input logic m2r,
                                     input logic rw, input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic [1:0] pcs,
                                     input logic pe);
    return {mr, mw, io, irw, rd, m2r, rw, asa, asb, aop, pcs, pe};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting in FETCH until FETCH or ERROR is re-entered,
  // stalling the data-memory stage for 'stall' cycles.
  task automatic run_instr(input logic [5:0] op, input int stall, input logic z);
    int         left;
    logic [3:0] st;
    left  = stall;
    cyc   = 0;
    rw_n  = 0;
    pe_n  = 0;
    ir_n  = 0;
    rd_n  = 0;
    wr_n  = 0;
    trace = '0;
    bus.opcode = op;
    bus.zero   = z;
    forever begin
      st = bus.state_dbg;
      if ((st == 4'd4 || st == 4'd6) && left > 0) begin
        bus.mem_ready = 1'b0;
        left--;
      end else begin
        bus.mem_ready = 1'b1;
      end
      #1;
      trace = {trace[27:0], st};
      if (cyc < 16) ctl_tr[cyc] = ctl;
      if (bus.reg_write) rw_n++;
      if (bus.pc_en) pe_n++;
      if (bus.ir_write) ir_n++;
      if (bus.mem_read && st != 4'd1) rd_n++;
      if (bus.mem_write) wr_n++;
      cyc++;
      tick();
      if (bus.state_dbg == 4'd1 || bus.state_dbg == 4'd12) break;
      if (cyc >= 40) begin
        check("instr_bound", 32'(cyc), 32'd0);
        break;
      end
    end
    bus.mem_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n         = 1'b0;
    bus.opcode    = 6'b000000;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    check("rst_state", 32'(bus.state_dbg), 32'd0);
    check("rst_ctl", 32'(ctl), 32'd0);
    check("rst_flags", 32'({bus.illegal_op, bus.bus_error}), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_hold", 32'(bus.state_dbg), 32'd0);
    tick();
    check("rst_to_fetch", 32'(bus.state_dbg), 32'd1);

    // R-type
    run_instr(6'b000000, 0, 1'b0);
    check("r_trace", trace, 32'h1278);
    check("r_cycles", 32'(cyc), 32'd4);
    check("r_fetch_ctl", 32'(ctl_tr[0]), 32'(cw(1,0,0,1,0,0,0,0,2'b01,2'b00,2'b00,1)));
    check("r_decode_ctl", 32'(ctl_tr[1]), 32'(cw(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0)));
    check("r_exec_ctl", 32'(ctl_tr[2]), 32'(cw(0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0)));
    check("r_wb_ctl", 32'(ctl_tr[3]), 32'(cw(0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0)));
    check("r_rw_count", 32'(rw_n), 32'd1);

    // lw with three stalled cycles in MEM_RD
    run_instr(6'b100011, 3, 1'b0);
    check("lw_trace", trace, 32'h12344445);
    check("lw_cycles", 32'(cyc), 32'd8);
    check("lw_read_cycles", 32'(rd_n), 32'd4);
    check("lw_addr_ctl", 32'(ctl_tr[2]), 32'(cw(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0)));
    check("lw_rd_ctl", 32'(ctl_tr[3]), 32'(cw(1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0)));
    check("lw_wb_ctl", 32'(ctl_tr[7]), 32'(cw(0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0)));
    check("lw_rw_count", 32'(rw_n), 32'd1);
    check("lw_ir_count", 32'(ir_n), 32'd1);

    // sw
    run_instr(6'b101011, 0, 1'b0);
    check("sw_trace", trace, 32'h1236);
    check("sw_cycles", 32'(cyc), 32'd4);
    check("sw_wr_ctl", 32'(ctl_tr[3]), 32'(cw(0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0)));
    check("sw_counts", 32'({8'(wr_n), 8'(rw_n)}), 32'h0100);

    // addi
    run_instr(6'b001000, 0, 1'b0);
    check("addi_trace", trace, 32'h1239);
    check("addi_wb_ctl", 32'(ctl_tr[3]), 32'(cw(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0)));

    // beq taken / not taken
    run_instr(6'b000100, 0, 1'b1);
    check("beq_t_trace", trace, 32'h12A);
    check("beq_t_cycles", 32'(cyc), 32'd3);
    check("beq_t_ctl", 32'(ctl_tr[2]), 32'(cw(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1)));
    check("beq_t_pcen", 32'(pe_n), 32'd2);
    run_instr(6'b000100, 0, 1'b0);
    check("beq_n_cycles", 32'(cyc), 32'd3);
    check("beq_n_ctl", 32'(ctl_tr[2]), 32'(cw(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0)));
    check("beq_n_pcen", 32'(pe_n), 32'd1);

    // j
    run_instr(6'b000010, 0, 1'b0);
    check("j_trace", trace, 32'h12B);
    check("j_ctl", 32'(ctl_tr[2]), 32'(cw(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1)));
    check("j_pcen", 32'(pe_n), 32'd2);

    // illegal opcode
    run_instr(6'b111111, 0, 1'b0);
    check("ill_trace", trace, 32'h12);
    check("ill_state", 32'(bus.state_dbg), 32'd12);
    check("ill_flags", 32'({bus.illegal_op, bus.bus_error}), 32'b10);
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = i[0];
      bus.zero      = 1'b1;
      #1;
      check("ill_ctl", 32'(ctl), 32'd0);
      tick();
      check("ill_stay", 32'(bus.state_dbg), 32'd12);
    end
    bus.zero = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("ill_rst", 32'({bus.state_dbg, bus.illegal_op, ctl}), 32'd0);
    tick();
    rst_n         = 1'b1;
    bus.opcode    = 6'b000000;
    bus.mem_ready = 1'b0;
    tick();
    check("ill_refetch", 32'(bus.state_dbg), 32'd1);

    // fetch timeout: mem_ready held low
    #1;
    check("to_fetch_ctl", 32'(ctl), 32'(cw(1,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0)));
    n = 0;
    while (bus.state_dbg == 4'd1 && n < 40) begin
      tick();
      n++;
    end
    check("to_cycles", 32'(n), 32'd16);
    check("to_state", 32'(bus.state_dbg), 32'd12);
    check("to_flags", 32'({bus.illegal_op, bus.bus_error}), 32'b01);
    check("to_ctl", 32'(ctl), 32'd0);

    // ready arriving on the 16th wait cycle completes the fetch
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) tick();
    check("edge_still_fetch", 32'(bus.state_dbg), 32'd1);
    bus.mem_ready = 1'b1;
    tick();
    check("edge_decode", 32'(bus.state_dbg), 32'd2);
    check("edge_no_err", 32'(bus.bus_error), 32'd0);

    // reset while waiting in MEM_WR
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.opcode = 6'b101011;
    tick();
    tick();
    bus.mem_ready = 1'b0;
    tick();
    check("wr_state", 32'(bus.state_dbg), 32'd6);
    check("wr_req", 32'(bus.mem_write), 32'd1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("wr_rst_drop", 32'({bus.state_dbg, ctl}), 32'd0);
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    check("wr_rel_rst", 32'(bus.state_dbg), 32'd0);
    tick();
    check("wr_rel_fetch", 32'(bus.state_dbg), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
